// File: rtl/iob_piso_ctrl.sv
// iob_piso_ctrl
//   Sequencer for an external parallel-in/serial-out shift register (MSB first).
//   Takes words over a valid/ready handshake, loads the PISO, then issues one
//   shift enable per bit period until the programmed number of bits has been
//   sent. Frames can run back-to-back with no idle cycle between them.
//
// Parameters
//   DATA_W  PISO width
//   DIV_W   width of the bit-period divisor
//   NB_W    width of the bit-count config (derived, do not override)
//
// Ports
//   clk, rst    clock (rising edge), synchronous active-high reset
//   cfg_div     bit period = cfg_div+1 clocks, sampled when a word is accepted
//   cfg_nbits   bits per frame, sampled at accept; 0 or >DATA_W means DATA_W
//   abort       ends the current frame immediately, no done pulse
//   in_valid    source word valid
//   in_data     source word; the frame is its top nbits, MSB first
//   in_ready    a word can be accepted this cycle
//   piso_ld     PISO parallel-load strobe
//   piso_en     PISO shift strobe
//   piso_p_in   PISO parallel data (in_data passed straight through)
//   tx_active   PISO serial output currently holds a frame bit
//   bit_stb     first cycle of each bit period
//   done        last cycle of the last bit of a frame
module iob_piso_ctrl #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16,
  parameter int NB_W   = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NB_W-1:0]   cfg_nbits,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              piso_ld,
  output logic              piso_en,
  output logic [DATA_W-1:0] piso_p_in,
  output logic              tx_active,
  output logic              bit_stb,
  output logic              done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [DIV_W-1:0]  div_q, div_q_nxt;
  logic [NB_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [NB_W-1:0]   nb_q, nb_q_nxt;
  logic              shifting, period_end, last, ready_int, accept;

  // Out-of-range bit counts fall back to a full-width frame.
  function automatic logic [NB_W-1:0] clamp_nbits(input logic [NB_W-1:0] n);
    if (n == '0 || n > NB_W'(DATA_W)) return NB_W'(DATA_W);
    return n;
  endfunction

  assign shifting   = (state == SHIFT);
  assign period_end = shifting & (div_cnt == div_q);
  assign last       = period_end & (bit_cnt == nb_q - NB_W'(1));
  // Ready on the last cycle of a frame lets the next word load as the final
  // bit leaves, so consecutive frames have no gap.
  assign ready_int  = ~rst & ~abort & (~shifting | last);
  assign accept     = in_valid & ready_int;

  assign in_ready  = ready_int;
  assign piso_ld   = accept;
  // The final bit period never shifts: the PISO is either reloaded or idle.
  assign piso_en   = ~rst & ~abort & period_end & ~last;
  assign piso_p_in = in_data;
  assign tx_active = ~rst & shifting;
  assign bit_stb   = ~rst & shifting & (div_cnt == '0);
  assign done      = ~rst & ~abort & last;

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    div_q_nxt   = div_q;
    nb_q_nxt    = nb_q;
    if (abort) begin
      state_nxt   = IDLE;
      div_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end else if (accept) begin
      state_nxt   = SHIFT;
      div_cnt_nxt = '0;
      bit_cnt_nxt = '0;
      div_q_nxt   = cfg_div;
      nb_q_nxt    = clamp_nbits(cfg_nbits);
    end else if (last) begin
      state_nxt   = IDLE;
      div_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end else if (period_end) begin
      div_cnt_nxt = '0;
      bit_cnt_nxt = bit_cnt + NB_W'(1);
    end else if (shifting) begin
      div_cnt_nxt = div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Frame configuration is only meaningful while SHIFT, so it needs no reset.
  always_ff @(posedge clk) begin
    div_q <= div_q_nxt;
    nb_q  <= nb_q_nxt;
  end

endmodule

// File: tb/tb_iob_piso_ctrl.sv
module tb_iob_piso_ctrl;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 4;
  localparam int NB_W   = $clog2(DATA_W) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [NB_W-1:0]   cfg_nbits = '0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, piso_ld, piso_en, tx_active, bit_stb, done;
  logic [DATA_W-1:0] piso_p_in;

  iob_piso_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_nbits(cfg_nbits),
    .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .piso_ld(piso_ld), .piso_en(piso_en),
    .piso_p_in(piso_p_in), .tx_active(tx_active), .bit_stb(bit_stb),
    .done(done)
  );

  always #5 clk = ~clk;

  // External PISO driven by the controller's strobes.
  logic [DATA_W-1:0] sr = '0;
  logic              s_out;
  always @(posedge clk) begin
    if (piso_ld)      sr <= piso_p_in;
    else if (piso_en) sr <= {sr[DATA_W-2:0], 1'b0};
  end
  assign s_out = sr[DATA_W-1];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: a frame is word/period/length plus the cycle offset within it.
  bit                m_busy = 1'b0;
  logic [DATA_W-1:0] m_word = '0;
  int                m_per = 1, m_n = 1, m_off = 0;
  int                n_done = 0;

  task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                       input int dv, input int nb, input logic ab,
                       output bit acc);
    int flen, nbc;
    bit e_last, e_ready, e_en;
    in_valid  = v;
    in_data   = d;
    cfg_div   = DIV_W'(dv);
    cfg_nbits = NB_W'(nb);
    abort     = ab;
    #1;
    acc = 1'b0;
    if (rst) begin
      chk("rst_ready",  int'(in_ready),  0);
      chk("rst_ld",     int'(piso_ld),   0);
      chk("rst_en",     int'(piso_en),   0);
      chk("rst_active", int'(tx_active), 0);
      chk("rst_stb",    int'(bit_stb),   0);
      chk("rst_done",   int'(done),      0);
      m_busy = 1'b0;
    end else begin
      flen    = m_n * m_per;
      e_last  = m_busy && (m_off == flen - 1);
      e_ready = !ab && (!m_busy || e_last);
      acc     = e_ready && v;
      e_en    = m_busy && !ab && (m_off % m_per == m_per - 1) && !e_last;
      chk("in_ready",  int'(in_ready),  int'(e_ready));
      chk("piso_ld",   int'(piso_ld),   int'(acc));
      chk("piso_en",   int'(piso_en),   int'(e_en));
      chk("tx_active", int'(tx_active), int'(m_busy));
      chk("bit_stb",   int'(bit_stb),   int'(m_busy && (m_off % m_per == 0)));
      chk("done",      int'(done),      int'(e_last && !ab));
      chk("p_in",      int'(piso_p_in), int'(d));
      if (m_busy) chk("s_out", int'(s_out), int'(m_word[DATA_W-1 - m_off / m_per]));
      if (e_last && !ab) n_done++;
      if (ab) m_busy = 1'b0;
      else if (acc) begin
        nbc    = (nb == 0 || nb > DATA_W) ? DATA_W : nb;
        m_busy = 1'b1;
        m_word = d;
        m_per  = dv + 1;
        m_n    = nbc;
        m_off  = 0;
      end else if (e_last) m_busy = 1'b0;
      else if (m_busy) m_off++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, DATA_W'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, a);
  endtask

  // Offer a word until it is accepted (bounded).
  task automatic feed(input logic [DATA_W-1:0] d, input int dv, input int nb);
    bit a = 1'b0;
    for (int i = 0; i < 300 && !a; i++) cycle(1'b1, d, dv, nb, 1'b0, a);
    if (!a) chk("feed_timeout", 0, 1);
  endtask

  initial begin
    bit a;
    int d0;
    // Reset held for two cycles, then idle with in_ready high.
    cycle(1'b1, 8'h3C, 0, 8, 1'b0, a);
    cycle(1'b1, 8'h3C, 0, 8, 1'b0, a);
    rst = 1'b0;
    idle(2);
    // Full byte at one bit per clock.
    feed(8'hA5, 0, 8);
    idle(10);
    // Slow, short frame.
    feed(8'hC0, 3, 4);
    idle(18);
    // Back-to-back frames with valid held.
    d0 = n_done;
    feed(8'h81, 1, 8);
    feed(8'h7E, 1, 8);
    idle(18);
    chk("b2b_done_count", n_done - d0, 2);
    // Bit-count clamping and single-bit frame.
    feed(8'hB2, 0, 0);
    idle(10);
    feed(8'h4D, 1, 15);
    idle(18);
    feed(8'h80, 2, 1);
    idle(5);
    // Abort during the third bit of a div=2 frame, then a normal frame.
    d0 = n_done;
    feed(8'hF0, 2, 8);
    idle(7);
    cycle(1'b1, 8'h11, 2, 8, 1'b1, a);
    idle(1);
    chk("abort_no_done", n_done - d0, 0);
    feed(8'h96, 2, 8);
    idle(26);
    // Reset mid-frame with a word pending.
    feed(8'hE7, 1, 8);
    idle(3);
    rst = 1'b1;
    cycle(1'b1, 8'h5A, 0, 8, 1'b0, a);
    rst = 1'b0;
    idle(2);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cycle(($urandom_range(0, 3) != 0), DATA_W'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 15),
            ($urandom_range(0, 59) == 0), a);
    end
    rst = 1'b0;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
